// File: rtl/wos_window_feeder.sv
// Producer-side feeder for the masked rank-order filter: buffers a framed sample
// stream and shifts it into the filter window with edge replication at both frame ends.
module wos_window_feeder #(
  parameter int N          = 7,
  parameter int data_bits  = 8,
  parameter int rank_bits  = $clog2(N+1),
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [data_bits-1:0] s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  input  logic [N-1:0]         cfg_mask,
  input  logic [rank_bits-1:0] cfg_rank,
  input  logic                 cfg_load,
  output logic [data_bits-1:0] o_sample,
  output logic                 o_shift,
  output logic                 o_win_valid,
  output logic                 o_last,
  output logic [N-1:0]         o_mask,
  output logic [rank_bits-1:0] o_rank_sel,
  output logic                 busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(N+1);
  localparam int H  = (N-1)/2;
  localparam logic [CW-1:0]        N_C      = CW'(N);
  localparam logic [CW-1:0]        H_C      = CW'(H);
  localparam logic [rank_bits-1:0] RANK_RST = rank_bits'((N+1)/2);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
  state_t state, state_nx;

  logic [data_bits:0]   mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic                 full, empty, push, pop;
  logic [data_bits-1:0] head_data;
  logic                 head_last;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign s_ready   = !full;
  assign push      = s_valid && !full;
  assign head_data = mem[rd_ptr[AW-1:0]][data_bits-1:0];
  assign head_last = mem[rd_ptr[AW-1:0]][data_bits];
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {s_last, s_data};
  end

  logic [CW-1:0]        cnt, cnt_nx, rep, rep_nx;
  logic [data_bits-1:0] last_sample, last_sample_nx, sample_nx, shift_val;
  logic [N-1:0]         shadow_mask, mask_nx;
  logic [rank_bits-1:0] shadow_rank, rank_nx;
  logic                 do_shift, shift_nx, win_nx, last_nx, frame_end;

  always_comb begin
    state_nx       = state;
    pop            = 1'b0;
    cnt_nx         = cnt;
    rep_nx         = rep;
    last_sample_nx = last_sample;
    sample_nx      = o_sample;
    mask_nx        = o_mask;
    rank_nx        = o_rank_sel;
    shift_nx       = 1'b0;
    win_nx         = 1'b0;
    last_nx        = 1'b0;
    do_shift       = 1'b0;
    shift_val      = last_sample;
    frame_end      = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          // A load landing on the same edge wins over the older shadow value.
          mask_nx  = cfg_load ? cfg_mask : shadow_mask;
          rank_nx  = cfg_load ? cfg_rank : shadow_rank;
          rep_nx   = H_C;
          cnt_nx   = '0;
          state_nx = FILL;
        end
      end
      FILL: begin
        do_shift  = 1'b1;
        shift_val = head_data;
        if (rep != '0) begin
          rep_nx = rep - 1'b1;
        end else begin
          pop            = 1'b1;
          last_sample_nx = head_data;
          frame_end      = head_last;
          state_nx       = RUN;
        end
      end
      RUN: begin
        if (!empty) begin
          do_shift       = 1'b1;
          shift_val      = head_data;
          pop            = 1'b1;
          last_sample_nx = head_data;
          frame_end      = head_last;
        end
      end
      FLUSH: begin
        do_shift = 1'b1;
        rep_nx   = rep - 1'b1;
        if (rep == CW'(1)) begin
          last_nx  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (frame_end) begin
      if (H == 0) begin
        last_nx  = 1'b1;
        state_nx = IDLE;
      end else begin
        rep_nx   = H_C;
        state_nx = FLUSH;
      end
    end
    if (do_shift) begin
      shift_nx  = 1'b1;
      sample_nx = shift_val;
      cnt_nx    = (cnt == N_C) ? cnt : cnt + 1'b1;
      win_nx    = (cnt_nx >= N_C);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      rep         <= '0;
      o_sample    <= '0;
      o_shift     <= 1'b0;
      o_win_valid <= 1'b0;
      o_last      <= 1'b0;
      o_mask      <= '1;
      o_rank_sel  <= RANK_RST;
      shadow_mask <= '1;
      shadow_rank <= RANK_RST;
    end else begin
      state       <= state_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt         <= cnt_nx;
      rep         <= rep_nx;
      o_sample    <= sample_nx;
      o_shift     <= shift_nx;
      o_win_valid <= win_nx;
      o_last      <= last_nx;
      o_mask      <= mask_nx;
      o_rank_sel  <= rank_nx;
      if (cfg_load) begin
        shadow_mask <= cfg_mask;
        shadow_rank <= cfg_rank;
      end
    end
  end

  always_ff @(posedge clk) begin
    last_sample <= last_sample_nx;
  end

endmodule

// File: tb/tb_wos_window_feeder.sv
// Directed bench for wos_window_feeder (N=7): shift sequences, window flags,
// back-to-back frames, config timing and asynchronous reset.
module tb_wos_window_feeder;
  localparam int N = 7;
  localparam int H = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data;
  logic       s_valid, s_last, s_ready;
  logic [6:0] cfg_mask;
  logic [2:0] cfg_rank;
  logic       cfg_load;
  logic [7:0] o_sample;
  logic       o_shift, o_win_valid, o_last, busy;
  logic [6:0] o_mask;
  logic [2:0] o_rank_sel;

  always #5 clk = ~clk;

  wos_window_feeder #(.N(7), .data_bits(8), .rank_bits(3), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .cfg_mask(cfg_mask), .cfg_rank(cfg_rank), .cfg_load(cfg_load),
    .o_sample(o_sample), .o_shift(o_shift), .o_win_valid(o_win_valid), .o_last(o_last),
    .o_mask(o_mask), .o_rank_sel(o_rank_sel), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Shift log captured on the falling edge, independent of stimulus.
  int q_s[$];
  bit q_w[$];
  bit q_l[$];
  int q_c[$];
  int cyc = 0;
  int hold_err = 0;
  int stall = 0;
  int nready = 0;
  int flag_err = 0;
  int prev = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (o_shift) begin
        q_s.push_back(int'(o_sample));
        q_w.push_back(o_win_valid);
        q_l.push_back(o_last);
        q_c.push_back(cyc);
        prev = int'(o_sample);
      end else begin
        if (int'(o_sample) != prev) hold_err++;
        if (busy) stall++;
        if (o_win_valid || o_last) flag_err++;
      end
      if (s_valid && !s_ready) nready++;
    end else begin
      prev = 0;
    end
  end

  int fr[$];
  int e_s[$];
  bit e_w[$];
  bit e_l[$];

  task automatic expect_frame();
    int seq[$];
    for (int i = 0; i < H; i++) seq.push_back(fr[0]);
    foreach (fr[i]) seq.push_back(fr[i]);
    for (int i = 0; i < H; i++) seq.push_back(fr[fr.size()-1]);
    foreach (seq[j]) begin
      e_s.push_back(seq[j]);
      e_w.push_back(j >= N-1);
      e_l.push_back(j == seq.size()-1);
    end
  endtask

  task automatic send(input int d, input bit l);
    int t;
    s_data  = 8'(d);
    s_last  = l;
    s_valid = 1'b1;
    t = 0;
    while (!s_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("send_timeout", 32'(t), 32'(0));
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input int gap_after, input int gap_len);
    foreach (fr[i]) begin
      send(fr[i], i == fr.size()-1);
      if (i == gap_after) repeat (gap_len) @(negedge clk);
    end
  endtask

  task automatic wait_shifts(input int base, input int n);
    int t;
    t = 0;
    while (q_s.size() - base < n && t < 500) begin
      @(negedge clk);
      t++;
    end
    while (busy && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) check("wait_timeout", 32'(t), 32'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic check_shifts(input string tag, input int base);
    check({tag, "_count"}, 32'(q_s.size() - base), 32'(e_s.size()));
    foreach (e_s[i]) begin
      if (base + i < q_s.size()) begin
        check($sformatf("%s_sample%0d", tag, i), 32'(q_s[base+i]), 32'(e_s[i]));
        check($sformatf("%s_win%0d", tag, i), 32'(q_w[base+i]), 32'(e_w[i]));
        check($sformatf("%s_last%0d", tag, i), 32'(q_l[base+i]), 32'(e_l[i]));
      end
    end
  endtask

  int base, st0, nr0, lcnt;

  initial begin
    rst = 1'b1; s_data = '0; s_valid = 1'b0; s_last = 1'b0;
    cfg_mask = '0; cfg_rank = '0; cfg_load = 1'b0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_shift", 32'(o_shift), 32'(0));
    check("rst_win", 32'(o_win_valid), 32'(0));
    check("rst_last", 32'(o_last), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_ready", 32'(s_ready), 32'(1));
    check("rst_mask", 32'(o_mask), 32'h7F);
    check("rst_rank", 32'(o_rank_sel), 32'(4));
    check("rst_sample", 32'(o_sample), 32'(0));
    rst = 1'b1;
    @(negedge clk);

    // Continuous five-sample frame.
    base = q_s.size(); e_s.delete(); e_w.delete(); e_l.delete();
    fr = '{10, 20, 30, 40, 50};
    expect_frame();
    check("exp_model_len", 32'(e_s.size()), 32'(11));
    send_frame(-1, 0);
    wait_shifts(base, 11);
    check_shifts("cont", base);
    check("cont_busy_end", 32'(busy), 32'(0));

    // Single-sample frame.
    base = q_s.size(); e_s.delete(); e_w.delete(); e_l.delete();
    fr = '{99};
    expect_frame();
    send_frame(-1, 0);
    wait_shifts(base, 7);
    check_shifts("single", base);

    // Gap after 30 long enough to drain the FIFO.
    base = q_s.size(); st0 = stall; e_s.delete(); e_w.delete(); e_l.delete();
    fr = '{10, 20, 30, 40, 50};
    expect_frame();
    send_frame(2, 8);
    wait_shifts(base, 11);
    check_shifts("gap", base);
    check("gap_stalled", 32'(stall > st0), 32'(1));
    check("hold_err", 32'(hold_err), 32'(0));
    check("idle_flag_err", 32'(flag_err), 32'(0));

    // Back-to-back frames: the second is pushed while the first drains.
    base = q_s.size(); nr0 = nready; e_s.delete(); e_w.delete(); e_l.delete();
    fr = '{10, 20, 30, 40, 50};
    expect_frame();
    send_frame(-1, 0);
    fr = '{1, 2, 3, 4, 5, 6};
    expect_frame();
    send_frame(-1, 0);
    wait_shifts(base, 23);
    check_shifts("b2b", base);
    check("b2b_backpressure", 32'(nready > nr0), 32'(1));
    if (q_c.size() >= base + 12)
      check("b2b_idle_gap", 32'(q_c[base+11] - q_c[base+10]), 32'(2));
    else
      check("b2b_idle_gap_missing", 32'(q_c.size() - base), 32'(23));

    // Config loaded mid-frame takes effect only at the next frame start.
    base = q_s.size(); e_s.delete(); e_w.delete(); e_l.delete();
    send(10, 1'b0);
    send(20, 1'b0);
    send(30, 1'b0);
    cfg_mask = 7'h0F; cfg_rank = 3'd2; cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    check("cfg_busy_mid", 32'(busy), 32'(1));
    check("cfg_mask_mid", 32'(o_mask), 32'h7F);
    check("cfg_rank_mid", 32'(o_rank_sel), 32'(4));
    send(40, 1'b0);
    send(50, 1'b1);
    wait_shifts(base, 11);
    check("cfg_mask_idle", 32'(o_mask), 32'h7F);
    check("cfg_rank_idle", 32'(o_rank_sel), 32'(4));
    base = q_s.size();
    send(5, 1'b1);
    @(negedge clk);
    check("cfg_mask_new", 32'(o_mask), 32'h0F);
    check("cfg_rank_new", 32'(o_rank_sel), 32'(2));
    wait_shifts(base, 7);

    // Asynchronous reset in the middle of a frame.
    base = q_s.size();
    send(10, 1'b0);
    send(20, 1'b0);
    send(30, 1'b0);
    repeat (8) @(negedge clk);
    check("ar_busy_before", 32'(busy), 32'(1));
    #2 rst = 1'b0;
    #1;
    check("ar_shift", 32'(o_shift), 32'(0));
    check("ar_win", 32'(o_win_valid), 32'(0));
    check("ar_last", 32'(o_last), 32'(0));
    check("ar_busy", 32'(busy), 32'(0));
    check("ar_ready", 32'(s_ready), 32'(1));
    check("ar_sample", 32'(o_sample), 32'(0));
    check("ar_mask", 32'(o_mask), 32'h7F);
    lcnt = 0;
    for (int i = base; i < q_l.size(); i++) lcnt += int'(q_l[i]);
    check("ar_no_last", 32'(lcnt), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    base = q_s.size(); e_s.delete(); e_w.delete(); e_l.delete();
    fr = '{10, 20, 30, 40, 50};
    expect_frame();
    send_frame(-1, 0);
    wait_shifts(base, 11);
    check_shifts("post_rst", base);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: time %0t limit 200000", $time);
    $fatal(1, "timeout");
  end
endmodule
